sap_u_sequencer: RTL

//   Microcoded control unit for SAP-U. Drives the control lines that SAP_U_tb

---
 rtl/sap_u_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sap_u_sequencer.sv
// SAP-U microcoded control unit: a T-state counter decoded with the IR opcode
// and ALU flags into one combinational control word per step.
module sap_u_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int NUM_STEPS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_carry,
    input  logic                flag_zero,
    output logic [2:0]          step,
    output logic                halted,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                ir_load,
    output logic                ir_out,
    output logic                ram_load_mar_reg,
    output logic                ram_output_enable,
    output logic                ram_control_signal,
    output logic                reg_a_load_n,
    output logic                reg_a_bus_enable_n,
    output logic                reg_b_load_n,
    output logic                alu_enable,
    output logic                alu_subtract,
    output logic                out_load
);

    localparam logic [2:0] T0        = 3'd0;
    localparam logic [2:0] T1        = 3'd1;
    localparam logic [2:0] T2        = 3'd2;
    localparam logic [2:0] T3        = 3'd3;
    localparam logic [2:0] T4        = 3'd4;
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    logic [2:0] r_step;
    logic       r_halted;
    logic       w_active;

    // Active-high internal view of every control; polarity fixed at the ports.
    logic w_pc_out, w_pc_inc, w_pc_load, w_ir_load, w_ir_out;
    logic w_mar_load, w_ram_out, w_ram_we;
    logic w_a_load, w_a_out, w_b_load, w_alu_en, w_alu_sub, w_out_load;

    assign w_active = run & ~r_halted & ~reset;

    // Step counter and sticky halt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (run && !r_halted) begin
            if (r_step == LAST_STEP) begin
                r_step <= T0;
            end else begin
                r_step <= r_step + 3'd1;
            end
            if (r_step == T2 && opcode == OP_HLT) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Control-word decode of (step, opcode, flags); idle whenever not active.
    always_comb begin
        w_pc_out   = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_ir_load  = 1'b0;
        w_ir_out   = 1'b0;
        w_mar_load = 1'b0;
        w_ram_out  = 1'b0;
        w_ram_we   = 1'b0;
        w_a_load   = 1'b0;
        w_a_out    = 1'b0;
        w_b_load   = 1'b0;
        w_alu_en   = 1'b0;
        w_alu_sub  = 1'b0;
        w_out_load = 1'b0;
        if (w_active) begin
            case (r_step)
                T0: begin
                    w_pc_out   = 1'b1;
                    w_mar_load = 1'b1;
                end
                T1: begin
                    w_ram_out = 1'b1;
                    w_ir_load = 1'b1;
                    w_pc_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            w_ir_out   = 1'b1;
                            w_mar_load = 1'b1;
                        end
                        OP_LDI: begin
                            w_ir_out = 1'b1;
                            w_a_load = 1'b1;
                        end
                        OP_JMP: begin
                            w_ir_out  = 1'b1;
                            w_pc_load = 1'b1;
                        end
                        OP_JC, OP_JZ: begin
                            // Conditional jumps sample the flag selected by the opcode.
                            if ((opcode == OP_JC) ? flag_carry : flag_zero) begin
                                w_ir_out  = 1'b1;
                                w_pc_load = 1'b1;
                            end else begin
                                w_ir_out  = 1'b0;
                                w_pc_load = 1'b0;
                            end
                        end
                        OP_OUT: begin
                            w_a_out    = 1'b1;
                            w_out_load = 1'b1;
                        end
                        default: w_ir_out = 1'b0;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            w_ram_out = 1'b1;
                            w_a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            w_ram_out = 1'b1;
                            w_b_load  = 1'b1;
                            w_alu_sub = (opcode == OP_SUB);
                        end
                        OP_STA: begin
                            w_a_out  = 1'b1;
                            w_ram_we = 1'b1;
                        end
                        default: w_ram_out = 1'b0;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            w_alu_en  = 1'b1;
                            w_a_load  = 1'b1;
                            w_alu_sub = (opcode == OP_SUB);
                        end
                        default: w_alu_en = 1'b0;
                    endcase
                end
                default: w_pc_out = 1'b0;
            endcase
        end else begin
            w_pc_out = 1'b0;
        end
    end

    assign step               = r_step;
    assign halted             = r_halted;
    assign pc_out             = w_pc_out;
    assign pc_inc             = w_pc_inc;
    assign pc_load            = w_pc_load;
    assign ir_load            = w_ir_load;
    assign ir_out             = w_ir_out;
    assign ram_load_mar_reg   = ~w_mar_load;
    assign ram_output_enable  = ~w_ram_out;
    assign ram_control_signal = w_ram_we;
    assign reg_a_load_n       = ~w_a_load;
    assign reg_a_bus_enable_n = ~w_a_out;
    assign reg_b_load_n       = ~w_b_load;
    assign alu_enable         = w_alu_en;
    assign alu_subtract       = w_alu_sub;
    assign out_load           = w_out_load;

endmodule
